// File: rtl/OpCodes.sv
// Shared opcode/width constants and the load-mode encoding used by the
// register-load path.
package OpCodes;

    localparam int NSIG          = 15;
    localparam int REGLD_PER_CLK = 4;
    localparam int LDBUF_DEPTH   = 4;

    typedef enum logic [1:0] {
        LD_PASS   = 2'd0,
        LD_BCAST  = 2'd1,
        LD_MASKED = 2'd2
    } ld_mode_t;

endpackage

// File: rtl/ld_lane_mux.sv
// Per-beat load-mode application across all lanes. Encoding 3 is reserved:
// it behaves as pass-through and raises the reserved flag.
module ld_lane_mux
    import OpCodes::*;
#(
    parameter int W     = OpCodes::NSIG + 1,
    parameter int LANES = OpCodes::REGLD_PER_CLK
) (
    input  logic [1:0]                  mode,
    input  logic [LANES-1:0]            mask,
    input  logic [LANES-1:0][W-1:0]     data_in,
    output logic [LANES-1:0][W-1:0]     data_out,
    output logic                        reserved
);

    // Select the stored lane values for the beat's mode.
    always_comb begin
        data_out = '0;
        reserved = 1'b0;
        case (mode)
            LD_PASS: begin
                data_out = data_in;
            end
            LD_BCAST: begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    data_out[i] = data_in[0];
                end
            end
            LD_MASKED: begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    data_out[i] = mask[i] ? data_in[i] : '0;
                end
            end
            default: begin
                data_out = data_in;
                reserved = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/vec_load_buffer.sv
// Register-load stage: applies the load mode at write time and queues beats
// in a DEPTH-entry FIFO with valid/ready on both sides, flush and thread tag.
module vec_load_buffer
    import OpCodes::*;
#(
    parameter int W     = OpCodes::NSIG + 1,
    parameter int LANES = OpCodes::REGLD_PER_CLK,
    parameter int DEPTH = OpCodes::LDBUF_DEPTH,
    parameter int TAG_W = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [1:0]                      in_mode,
    input  logic [LANES-1:0]                in_mask,
    input  logic [TAG_W-1:0]                in_tag,
    input  logic [LANES-1:0][W-1:0]         in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES-1:0][W-1:0]         out_data,
    output logic [LANES-1:0]                out_mask,
    output logic [TAG_W-1:0]                out_tag,
    output logic [$clog2(DEPTH):0]          count,
    output logic                            err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [LANES-1:0][W-1:0] mem_data [DEPTH];
    logic [LANES-1:0]        mem_mask [DEPTH];
    logic [TAG_W-1:0]        mem_tag  [DEPTH];

    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;

    logic [LANES-1:0][W-1:0] mode_data;
    logic                    mode_reserved;
    logic                    push;
    logic                    pop;

    ld_lane_mux #(
        .W     (W),
        .LANES (LANES)
    ) u_lane_mux (
        .mode     (in_mode),
        .mask     (in_mask),
        .data_in  (in_data),
        .data_out (mode_data),
        .reserved (mode_reserved)
    );

    // Handshake status and transfer qualifiers; no look-ahead on same-cycle pop.
    always_comb begin
        in_ready  = (count < FULL);
        out_valid = (count != '0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
    end

    // Head entry is presented directly from storage.
    always_comb begin
        out_data = mem_data[rd_ptr];
        out_mask = mem_mask[rd_ptr];
        out_tag  = mem_tag[rd_ptr];
    end

    // Storage writes; flush leaves contents in place, reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_mask[i] <= '0;
                mem_tag[i]  <= '0;
            end
        end else if (push) begin
            mem_data[wr_ptr] <= mode_data;
            mem_mask[wr_ptr] <= in_mask;
            mem_tag[wr_ptr]  <= in_tag;
        end
    end

    // Pointers and occupancy; flush takes priority over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky reserved-mode indicator, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (push && mode_reserved) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vec_load_buffer.sv
// Directed testbench for vec_load_buffer (W=16, LANES=4, DEPTH=4, TAG_W=4).
module tb_vec_load_buffer;

    localparam int W     = 16;
    localparam int LANES = 4;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               in_mode;
    logic [LANES-1:0]         in_mask;
    logic [TAG_W-1:0]         in_tag;
    logic [LANES-1:0][W-1:0]  in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES-1:0][W-1:0]  out_data;
    logic [LANES-1:0]         out_mask;
    logic [TAG_W-1:0]         out_tag;
    logic [$clog2(DEPTH):0]   count;
    logic                     err;

    int checks = 0;
    int errors = 0;

    vec_load_buffer #(
        .W     (W),
        .LANES (LANES),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_mask   (in_mask),
        .in_tag    (in_tag),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_tag   (out_tag),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    function automatic logic [63:0] all4(input int v);
        return {4{16'(v)}};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] mk,
                         input logic [3:0] t, input logic [63:0] d);
        in_valid = v;
        in_mode  = m;
        in_mask  = mk;
        in_tag   = t;
        in_data  = d;
    endtask

    int mc;
    int nxt;
    int head;
    logic exp_ready;

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'd0, 4'h0, 4'h0, 64'h0);
        #12;
        // reset state
        check("rst_count",     64'(count),     64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_mask",  64'(out_mask),  64'd0);
        check("rst_out_tag",   64'(out_tag),   64'd0);
        check("rst_err",       64'(err),       64'd0);
        rst = 1'b0;
        step();

        // modes: pass, broadcast, masked
        drive(1'b1, 2'd0, 4'b1111, 4'd1, pack4(1, 2, 3, 4));
        step();
        check("pass_latency_valid", 64'(out_valid), 64'd1);
        check("pass_latency_data",  64'(out_data),  pack4(1, 2, 3, 4));
        check("pass_count",         64'(count),     64'd1);
        drive(1'b1, 2'd1, 4'b1010, 4'd2, pack4(7, 9, 9, 9));
        step();
        drive(1'b1, 2'd2, 4'b0101, 4'd3, pack4(5, 6, 7, 8));
        step();
        drive(1'b0, 2'd0, 4'h0, 4'h0, 64'h0);
        check("modes_count", 64'(count), 64'd3);
        out_ready = 1'b1;
        check("pop1_data", 64'(out_data), pack4(1, 2, 3, 4));
        check("pop1_tag",  64'(out_tag),  64'd1);
        check("pop1_mask", 64'(out_mask), 64'b1111);
        step();
        check("pop2_data", 64'(out_data), all4(7));
        check("pop2_tag",  64'(out_tag),  64'd2);
        check("pop2_mask", 64'(out_mask), 64'b1010);
        step();
        check("pop3_data", 64'(out_data), pack4(5, 0, 7, 0));
        check("pop3_tag",  64'(out_tag),  64'd3);
        check("pop3_mask", 64'(out_mask), 64'b0101);
        step();
        check("modes_empty_valid", 64'(out_valid), 64'd0);
        check("modes_empty_count", 64'(count),     64'd0);
        out_ready = 1'b0;

        // full / back-pressure, then drain across pointer wrap
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd0, 4'hF, 4'd0, all4(i));
            step();
        end
        check("full_count",    64'(count),    64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        mc = 4; nxt = 4; head = 0;
        for (int cyc = 0; cyc < 20 && head < 8; cyc++) begin
            exp_ready = (mc < DEPTH);
            drive(nxt < 8, 2'd0, 4'hF, 4'd0, all4(nxt));
            check("wrap_in_ready", 64'(in_ready), 64'(exp_ready));
            if (mc > 0) begin
                check("wrap_head", 64'(out_data), all4(head));
            end
            step();
            if (mc > 0) begin
                head++;
                mc--;
            end
            if (nxt < 8 && exp_ready) begin
                nxt++;
                mc++;
            end
        end
        check("wrap_all_popped", 64'(head), 64'd8);
        check("wrap_empty", 64'(count), 64'd0);
        drive(1'b0, 2'd0, 4'h0, 4'h0, 64'h0);
        out_ready = 1'b0;

        // concurrent push/pop at count=2
        drive(1'b1, 2'd0, 4'hF, 4'd0, all4(100));
        step();
        drive(1'b1, 2'd0, 4'hF, 4'd0, all4(101));
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'd0, 4'hF, 4'd0, all4(102 + i));
            check("conc_head",  64'(out_data), all4(100 + i));
            check("conc_count", 64'(count),    64'd2);
            step();
        end
        drive(1'b0, 2'd0, 4'h0, 4'h0, 64'h0);
        out_ready = 1'b0;
        check("conc_end_count", 64'(count),    64'd2);
        check("conc_end_head",  64'(out_data), all4(110));

        // flush beats push and pop (offered beat uses reserved mode)
        drive(1'b1, 2'd0, 4'hF, 4'd0, all4(200));
        step();
        check("flush_pre_count", 64'(count), 64'd3);
        flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, 2'd3, 4'hF, 4'd5, all4(16'hAA));
        step();
        flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'd0, 4'h0, 4'h0, 64'h0);
        check("flush_count",     64'(count),     64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready",  64'(in_ready),  64'd1);
        check("flush_err",       64'(err),       64'd0);
        drive(1'b1, 2'd0, 4'hF, 4'd6, all4(16'h55));
        step();
        drive(1'b0, 2'd0, 4'h0, 4'h0, 64'h0);
        check("flush_drop_count", 64'(count),    64'd1);
        check("flush_drop_data",  64'(out_data), all4(16'h55));
        check("flush_drop_tag",   64'(out_tag),  64'd6);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // reserved mode
        drive(1'b1, 2'd3, 4'hF, 4'd7, pack4(9, 8, 7, 6));
        check("rsv_err_before", 64'(err), 64'd0);
        step();
        drive(1'b0, 2'd0, 4'h0, 4'h0, 64'h0);
        check("rsv_err",  64'(err),      64'd1);
        check("rsv_data", 64'(out_data), pack4(9, 8, 7, 6));
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("rsv_err_after_flush", 64'(err),   64'd1);
        check("rsv_flush_count",     64'(count), 64'd0);

        // asynchronous reset mid-stream
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 2'd0, 4'hF, 4'd0, all4(i));
            step();
        end
        drive(1'b0, 2'd0, 4'h0, 4'h0, 64'h0);
        check("arst_pre_count", 64'(count), 64'd3);
        #3 rst = 1'b1;
        #1;
        check("arst_count",     64'(count),     64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready",  64'(in_ready),  64'd1);
        check("arst_out_data",  64'(out_data),  64'd0);
        check("arst_err",       64'(err),       64'd0);
        #2 rst = 1'b0;
        step();
        check("arst_post_data", 64'(out_data), 64'd0);
        drive(1'b1, 2'd0, 4'hF, 4'd1, all4(16'h1111));
        step();
        drive(1'b0, 2'd0, 4'h0, 4'h0, 64'h0);
        check("arst_push_valid", 64'(out_valid), 64'd1);
        check("arst_push_data",  64'(out_data),  all4(16'h1111));
        check("arst_push_count", 64'(count),     64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
